// File: rtl/mm_tile_pkg.sv
// Shared types and helpers for the output-stationary GEMM tile engine.
// Tile FSM states, datapath width helpers and a saturating adder.
package mm_tile_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  typedef struct packed {
    logic        clip;
    logic [63:0] val;
  } sat_res_t;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int tree_w(input int dw, input int len);
    return 2 * dw + $clog2(len);
  endfunction

  // Add two sign-extended values, clamp to a w-bit signed range.
  function automatic sat_res_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    s      = a + b;
    hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo     = -hi - 64'sd1;
    r.clip = 1'b0;
    r.val  = s;
    if (s > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (s < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_dot_lane.sv
// One (i,j) cell: product registers, adder tree, accumulator.
// MM_ACC_SAT_EN selects saturating accumulate and adds the clip port.
module mm_dot_lane
  import mm_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s1_en,
  input  logic                         s2_en,
  input  logic                         first,
  input  logic [DATA_WIDTH*LENGTH-1:0] a_vec,
  input  logic [DATA_WIDTH*LENGTH-1:0] b_vec,
`ifdef MM_ACC_SAT_EN
  output logic                         clip,
`endif
  output logic [ACC_WIDTH-1:0]         acc
);

  localparam int PW = prod_w(DATA_WIDTH);
  localparam int TW = tree_w(DATA_WIDTH, LENGTH);

  logic signed [PW-1:0]        prod_q [LENGTH];
  logic signed [TW-1:0]        tsum;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] acc_q;

  // Stage 1: register the K-lane signed products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LENGTH; k++) prod_q[k] <= '0;
    end else if (s1_en) begin
      for (int k = 0; k < LENGTH; k++)
        prod_q[k] <=
          PW'($signed(a_vec[k*DATA_WIDTH +: DATA_WIDTH])) *
          PW'($signed(b_vec[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Product tree sum, grown enough to never overflow.
  always_comb begin
    tsum = '0;
    for (int k = 0; k < LENGTH; k++)
      tsum = tsum + TW'(prod_q[k]);
  end

  assign ext = ACC_WIDTH'(tsum);

`ifdef MM_ACC_SAT_EN
  sat_res_t sr;
  logic     unused_hi;

  // Saturating sum of accumulator and this slice's contribution.
  always_comb begin
    sr = sat_add(64'(acc_q), 64'(ext), ACC_WIDTH);
  end

  assign unused_hi = ^sr.val[63:ACC_WIDTH];
  assign clip      = s2_en && !first && sr.clip;

  // Stage 2: first slice loads, later slices add with clamping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_q <= '0;
    else if (s2_en)
      acc_q <= first ? ext : ACC_WIDTH'(sr.val);
  end
`else
  // Stage 2: first slice loads, later slices add modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_q <= '0;
    else if (s2_en)
      acc_q <= first ? ext : acc_q + ext;
  end
`endif

  assign acc = acc_q;

endmodule

// File: rtl/mm_tile_accum.sv
// Output-stationary GEMM tile engine: slice in, finished tile out.
// MM_ACC_SAT_EN enables saturating accumulate and the sat_flag port.
module mm_tile_accum
  import mm_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 4,
  parameter int COL_NUM    = 4,
  parameter int LENGTH     = 4,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_last,
  input  logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0]  mat,
  input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]  fil,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ACC_WIDTH*ROW_NUM*COL_NUM-1:0]  res,
  output logic [15:0]                           beat_count,
`ifdef MM_ACC_SAT_EN
  output logic                                  sat_flag,
`endif
  output logic                                  busy
);

  localparam int SW = DATA_WIDTH * LENGTH;

  state_t state_q;
  state_t state_n;
  logic   rdy_q;
  logic   v1_q;
  logic   first1_q;
  logic   accept;
  logic   hs;

  assign accept    = in_valid && rdy_q;
  assign in_ready  = rdy_q;
  assign out_valid = (state_q == OUT);
  assign hs        = out_valid && out_ready;
  assign busy      = !(state_q == ACCUM && beat_count == 16'd0);

  // Next-state logic for the tile sequencing.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ACCUM: if (accept && in_last) state_n = DRAIN;
      DRAIN: if (!v1_q) state_n = OUT;
      OUT:   if (out_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // State, registered ready and stage-1 valid/first tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ACCUM;
      rdy_q    <= 1'b0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      rdy_q    <= (state_n == ACCUM);
      v1_q     <= accept;
      first1_q <= accept && (beat_count == 16'd0);
    end
  end

  // Slices accepted in the current tile, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_count <= 16'd0;
    else if (hs)
      beat_count <= 16'd0;
    else if (accept && beat_count != 16'hFFFF)
      beat_count <= beat_count + 16'd1;
  end

`ifdef MM_ACC_SAT_EN
  logic [ROW_NUM*COL_NUM-1:0] clip_w;

  // Sticky per-tile clip indicator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (hs)
      sat_flag <= 1'b0;
    else if (|clip_w)
      sat_flag <= 1'b1;
  end
`endif

  for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
    for (genvar j = 0; j < COL_NUM; j++) begin : g_col
      logic [SW-1:0] b_col;

      for (genvar k = 0; k < LENGTH; k++) begin : g_k
        assign b_col[k*DATA_WIDTH +: DATA_WIDTH] =
          fil[(k*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH];
      end

      mm_dot_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .LENGTH    (LENGTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
        .clk  (clk),
        .reset(reset),
        .s1_en(accept),
        .s2_en(v1_q),
        .first(first1_q),
        .a_vec(mat[i*SW +: SW]),
        .b_vec(b_col),
`ifdef MM_ACC_SAT_EN
        .clip (clip_w[i*COL_NUM+j]),
`endif
        .acc  (res[(i*COL_NUM+j)*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_mm_tile_accum.sv
// Scoreboard bench for mm_tile_accum (32-bit and 18-bit builds).
// Random and directed slices checked against an arithmetic model.
module tb_mm_tile_accum;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int L  = 4;
  localparam int AW = 32;
  localparam int AS = 18;
  localparam int N  = R * C;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_last;
  logic             out_ready;
  logic [DW*R*L-1:0] mat;
  logic [DW*L*C-1:0] fil;
  logic             in_ready, out_valid, busy32;
  logic             ir18, ov18, busy18;
  logic [AW*N-1:0]  res32;
  logic [AS*N-1:0]  res18;
  logic [15:0]      bc32, bc18;
`ifdef MM_ACC_SAT_EN
  logic             sat32, sat18;
`endif

  mm_tile_accum #(
    .DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C),
    .LENGTH(L), .ACC_WIDTH(AW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .mat(mat), .fil(fil),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res32), .beat_count(bc32),
`ifdef MM_ACC_SAT_EN
    .sat_flag(sat32),
`endif
    .busy(busy32)
  );

  mm_tile_accum #(
    .DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C),
    .LENGTH(L), .ACC_WIDTH(AS)
  ) u_dut18 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(ir18),
    .in_last(in_last), .mat(mat), .fil(fil),
    .out_valid(ov18), .out_ready(out_ready),
    .res(res18), .beat_count(bc18),
`ifdef MM_ACC_SAT_EN
    .sat_flag(sat18),
`endif
    .busy(busy18)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW*N-1:0] r32;
    logic [AS*N-1:0] r18;
    logic            sat;
    int              cyc;
  } exp_t;

  exp_t q[$];

  // Behavioural model: plain integer dot products per cell.
  int     sa [R][L];
  int     sb [L][C];
  longint m32 [R][C];
  longint m18 [R][C];
  logic   msat;
  int     beats;
  int     acc_cyc;
  int     hs_cyc;
  int     ordy_mode;

  function automatic longint wrap(input longint x, input int w);
    longint m;
    m = x & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint get32(input int idx);
    return longint'($signed(res32[idx*AW +: AW]));
  endfunction

  function automatic longint get18(input int idx);
    return longint'($signed(res18[idx*AS +: AS]));
  endfunction

  task automatic model_accept(input bit last);
    longint s, t, hi;
    exp_t   e;
    hi = (longint'(1) << (AS - 1)) - 1;
    if (beats == 0) msat = 1'b0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int k = 0; k < L; k++) s += sa[i][k] * sb[k][j];
        if (beats == 0) begin
          m32[i][j] = wrap(s, AW);
          m18[i][j] = wrap(s, AS);
        end else begin
          m32[i][j] = wrap(m32[i][j] + s, AW);
          t = m18[i][j] + s;
`ifdef MM_ACC_SAT_EN
          if (t > hi) begin t = hi; msat = 1'b1; end
          else if (t < -hi - 1) begin t = -hi - 1; msat = 1'b1; end
          m18[i][j] = t;
`else
          m18[i][j] = wrap(t, AS);
`endif
        end
      end
    beats++;
    if (last) begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          e.r32[(i*C+j)*AW +: AW] = m32[i][j][AW-1:0];
          e.r18[(i*C+j)*AS +: AS] = m18[i][j][AS-1:0];
        end
      e.sat = msat;
      e.cyc = acc_cyc;
      q.push_back(e);
      beats = 0;
    end
  endtask

  task automatic set_all(input int av, input int bv);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < L; k++) sa[i][k] = av;
    for (int k = 0; k < L; k++)
      for (int j = 0; j < C; j++) sb[k][j] = bv;
  endtask

  task automatic set_rand();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < L; k++)
        sa[i][k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < L; k++)
      for (int j = 0; j < C; j++)
        sb[k][j] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send_slice(input bit last, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    for (int i = 0; i < R; i++)
      for (int k = 0; k < L; k++)
        mat[(i*L+k)*DW +: DW] = sa[i][k][DW-1:0];
    for (int k = 0; k < L; k++)
      for (int j = 0; j < C; j++)
        fil[(k*C+j)*DW +: DW] = sb[k][j][DW-1:0];
    in_valid = 1'b1;
    in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    acc_cyc = cyc + 1;
    model_accept(last);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_ov();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ov_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res", res32 == '0, 1);
    chk("rst_beat", bc32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_in_ready2", in_ready, 0);
    beats = 0;
    msat  = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  // out_ready: random, held low, or held high.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops expected tiles on output handshakes.
  logic            prev_ov   = 1'b0;
  logic            prev_ordy = 1'b0;
  logic [AW*N-1:0] held32;
  logic [AS*N-1:0] held18;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!prev_ov) begin
          if (q.size() == 0) chk("spurious_ov", 1, 0);
          else chk("latency", cyc, q[0].cyc + 2);
        end else if (!prev_ordy) begin
          chk("res_hold32", res32 == held32, 1);
          chk("res_hold18", res18 == held18, 1);
        end
        chk("in_ready_in_out", in_ready, 0);
        if (out_ready && q.size() > 0) begin
          e = q.pop_front();
          hs_cyc = cyc + 1;
          chk("ov18", ov18, 1);
          for (int n = 0; n < N; n++) begin
            chk($sformatf("res32[%0d]", n), get32(n),
                longint'($signed(e.r32[n*AW +: AW])));
            chk($sformatf("res18[%0d]", n), get18(n),
                longint'($signed(e.r18[n*AS +: AS])));
          end
`ifdef MM_ACC_SAT_EN
          chk("sat32", sat32, 0);
          chk("sat18", sat18, e.sat);
`endif
        end
      end
      prev_ov   = out_valid;
      prev_ordy = out_ready;
      held32    = res32;
      held18    = res18;
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    mat       = '0;
    fil       = '0;
    ordy_mode = 1;
    beats     = 0;
    msat      = 1'b0;
    hs_cyc    = 0;
    acc_cyc   = 0;
    @(posedge clk);
    do_reset();

    // single slice, dot product 70 at cell (0,0)
    set_all(0, 0);
    for (int k = 0; k < L; k++) begin
      sa[0][k] = k + 1;
      sb[k][0] = k + 5;
    end
    send_slice(1, 0);
    wait_ov();
    chk("t1_res00", get32(0), 70);
    ordy_mode = 2;
    wait_idle();

    // three back-to-back slices of ones
    ordy_mode = 1;
    set_all(1, 1);
    send_slice(0, 0);
    send_slice(0, 0);
    send_slice(1, 0);
    @(negedge clk);
    chk("t2_rdy_low", in_ready, 0);
    wait_ov();
    chk("t2_beats", bc32, 3);
    chk("t2_busy", busy32, 1);
    chk("t2_res", get32(N - 1), 12);
    ordy_mode = 2;
    wait_idle();
    chk("t2_beats_clr", bc32, 0);
    chk("t2_idle_busy", busy32, 0);
    chk("t2_rdy_back", in_ready, 1);

    // signed corners
    ordy_mode = 1;
    set_all(-128, -128);
    send_slice(1, 0);
    wait_ov();
    chk("t3_neg128", get32(5), 65536);
    ordy_mode = 2;
    wait_idle();
    ordy_mode = 1;
    set_all(-1, 3);
    send_slice(1, 0);
    wait_ov();
    chk("t3_neg12", get32(7), -12);
    ordy_mode = 2;
    wait_idle();

    // backpressure, then immediate next tile
    ordy_mode = 1;
    set_rand();
    send_slice(0, 0);
    set_rand();
    send_slice(1, 1);
    wait_ov();
    repeat (5) begin
      @(negedge clk);
      chk("t4_rdy_low", in_ready, 0);
    end
    @(posedge clk); #1;
    ordy_mode = 2;
    set_rand();
    send_slice(1, 0);
    chk("t4_next_accept", acc_cyc, hs_cyc + 1);
    wait_idle();

    // reset after 2 of 4 slices discards the tile
    set_all(1, 1);
    send_slice(0, 0);
    send_slice(0, 0);
    do_reset();
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_ov", out_valid, 0);
    end
    @(posedge clk); #1;
    ordy_mode = 1;
    send_slice(1, 0);
    wait_ov();
    chk("t5_fresh", get32(0), 4);
    ordy_mode = 2;
    wait_idle();

    // 18-bit accumulator overflow
    ordy_mode = 1;
    set_all(127, 127);
    send_slice(0, 0);
    send_slice(0, 0);
    send_slice(1, 0);
    wait_ov();
    chk("t6_res32", get32(0), 193548);
`ifdef MM_ACC_SAT_EN
    chk("t6_res18", get18(0), 131071);
    chk("t6_sat", sat18, 1);
`else
    chk("t6_res18", get18(0), -68596);
`endif
    ordy_mode = 2;
    wait_idle();

    // random tiles, bubbles, random backpressure
    ordy_mode = 0;
    for (int t = 0; t < 25; t++) begin
      int ns;
      ns = int'($urandom_range(1, 4));
      for (int s = 0; s < ns; s++) begin
        set_rand();
        send_slice(s == ns - 1, int'($urandom_range(0, 2)));
      end
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_tile_accum.md
Name: mm_tile_accum

Overview:
Output-stationary GEMM tile engine, next generation of the register-fed full-matrix multiplier. Streams K-slices of an A row-block (ROW_NUM x LENGTH) and a B column-block (LENGTH x COL_NUM) over a valid/ready interface. Accumulates ROW_NUM x COL_NUM dot products across an arbitrary number of slices, then presents the finished tile on a held valid/ready output. Sits between the operand buffers and the result writeback in the gemmt datapath.

Parameters:
DATA_WIDTH, 8, operand element width, two's complement
ROW_NUM, 4, rows of the A block / result tile
COL_NUM, 4, columns of the B block / result tile
LENGTH, 4, K elements per slice (dot-product lanes per cell)
ACC_WIDTH, 32, accumulator / result element width; must be >= 2*DATA_WIDTH+$clog2(LENGTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  slice valid
in_ready  out  1  slice accepted when in_valid && in_ready
in_last  in  1  marks the final K-slice of the tile
mat  in  DATA_WIDTH*ROW_NUM*LENGTH  A slice, element (i,k) at index i*LENGTH+k
fil  in  DATA_WIDTH*LENGTH*COL_NUM  B slice, element (k,j) at index k*COL_NUM+j
out_valid  out  1  result tile valid
out_ready  in  1  result consumed when out_valid && out_ready
res  out  ACC_WIDTH*ROW_NUM*COL_NUM  result, element (i,j) at index i*COL_NUM+j
beat_count  out  16  slices accepted in current tile, saturates at 16'hFFFF
busy  out  1  high in any state except ACCUM with beat_count==0

Behaviour:
- Reset (async, active-high): state ACCUM, in_ready 0 during reset then 1 next cycle, out_valid 0, res 0, beat_count 0, all accumulators and pipeline valids 0.
- FSM: ACCUM -> DRAIN on accepted in_last; DRAIN -> OUT when pipeline empty; OUT -> ACCUM on out handshake.
- in_ready = 1 only in ACCUM; 0 in DRAIN and OUT.
- Pipeline per cell: stage 1 registers LENGTH signed products (2*DATA_WIDTH each); stage 2 adds sign-extended product tree sum into the accumulator.
- First slice of a tile loads the accumulator (no add of stale value); later slices add. No clear cycle between tiles.
- Arithmetic: signed, sign-extended to ACC_WIDTH, wrap modulo 2^ACC_WIDTH (default build).
- Latency: out_valid rises exactly 2 cycles after the clock edge accepting the in_last slice. Back-to-back slices every cycle in ACCUM.
- res registered; held bit-stable while out_valid && !out_ready.
- After out handshake: out_valid 0 next cycle, in_ready 1 same next cycle, beat_count 0.
- Single-slice tile (in_last on first beat) is legal; result = one dot product.
- in_valid low in ACCUM: no state change, bubbles allowed between slices.
- in_last without in_valid: ignored.
- Reset mid-tile or mid-OUT: partial sums discarded; no out_valid for the aborted tile.

Optional Feature:
MM_ACC_SAT_EN: when defined, stage-2 accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Adds output port sat_flag (1 bit), sticky per tile, set if any cell clipped, cleared with the out handshake and at reset. When undefined: wrap-around arithmetic, no sat_flag port.

Decomposition:
- Package mm_tile_pkg: state enum (ACCUM, DRAIN, OUT), product/tree-sum width localparam functions, saturating-add function.
- Sub-module mm_dot_lane: one (i,j) cell holding product registers, adder tree, accumulator with load/add select and optional saturation; instantiated ROW_NUM*COL_NUM times by a generate loop. FSM and handshakes live in the top.

Test Plan:
- Single slice, A row0=[1,2,3,4], B col0=[5,6,7,8], in_last=1 -> res(0,0)=70, out_valid exactly 2 cycles after accept.
- Three back-to-back slices, all elements 1 -> every res element 12, beat_count 3 before handshake, in_ready low from the cycle after the last accept until handshake.
- Signed: all elements -128, one slice -> every res element 65536. A=-1, B=3 -> -12.
- Backpressure: out_ready held 0 for 5 cycles -> res stable, in_ready 0. Next tile accepted the cycle after the handshake; its result excludes the prior tile's sums.
- Reset asserted after 2 of 4 slices -> out_valid stays 0. Fresh single slice of ones -> res 4, not 12.
- ACC_WIDTH=18, elements 127, 3 slices (total 193548): with MM_ACC_SAT_EN -> 131071 and sat_flag 1. Without -> wraps to -68596.
